// File: rtl/vision_pkg.sv
// Shared vision-pipeline types: frame geometry defaults, derived
// widths, bbox tracker FSM states and the published result bundle.
package vision_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  localparam int XW = $clog2(DEF_IMG_W);
  localparam int YW = $clog2(DEF_IMG_H);
  localparam int CW = $clog2(DEF_IMG_W * DEF_IMG_H + 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACCUM,
    PUBLISH
  } bbox_state_t;

  typedef struct packed {
    logic          found;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [CW-1:0] count;
  } bbox_result_t;

endpackage

// File: rtl/raster_pos_counter.sv
// Raster x/y position tracker for mask streams: wraps at row end,
// flags the last pixel of a frame, and restarts at (0,0) on sof.
module raster_pos_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int XN = $clog2(W),
  parameter int YN = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sof,
  output logic [XN-1:0] x,
  output logic [YN-1:0] y,
  output logic          last
);

  localparam logic [XN-1:0] X_END = XN'(W - 1);
  localparam logic [YN-1:0] Y_END = YN'(H - 1);

  logic [XN-1:0] x_q;
  logic [YN-1:0] y_q;

  // an sof beat is always pixel (0,0), whatever the counters held
  assign x    = sof ? '0 : x_q;
  assign y    = sof ? '0 : y_q;
  assign last = (x == X_END) && (y == Y_END);

  // advance past the current beat's position; wraps to (0,0) at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      if (x == X_END) begin
        x_q <= '0;
        y_q <= (y == Y_END) ? '0 : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/mask_bbox_tracker.sv
// Per-frame bounding box of a raster 1-bit mask, one result per frame
// on valid/ready. MASK_BBOX_COUNT_EN adds the set-pixel counter.
module mask_bbox_tracker
  import vision_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int MIN_PIXELS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pixel,
  input  logic i_pixel_valid,
  input  logic i_sof,
  output logic o_bbox_valid,
  input  logic i_bbox_ready,
  output logic o_found,
  output logic [$clog2(IMG_W)-1:0] o_x_min,
  output logic [$clog2(IMG_W)-1:0] o_x_max,
  output logic [$clog2(IMG_H)-1:0] o_y_min,
  output logic [$clog2(IMG_H)-1:0] o_y_max,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] o_pixel_count,
  output logic o_overrun
);

  localparam int XN = $clog2(IMG_W);
  localparam int YN = $clog2(IMG_H);
  localparam int CN = $clog2(IMG_W * IMG_H + 1);

  bbox_state_t  state_q, state_d;
  bbox_result_t res_q, res_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  logic          have_q, have_d;
  logic [XN-1:0] xmin_q, xmin_d;
  logic [XN-1:0] xmax_q, xmax_d;
  logic [YN-1:0] ymin_q, ymin_d;
  logic [YN-1:0] ymax_q, ymax_d;
`ifdef MASK_BBOX_COUNT_EN
  logic [CN-1:0] cnt_q, cnt_d;
`endif

  logic          beat;
  logic          last;
  logic [XN-1:0] px;
  logic [YN-1:0] py;

  assign beat = i_pixel_valid &
    ((state_q == ACCUM) |
     ((state_q == WAIT_SOF) & i_sof));

  raster_pos_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .XN (XN),
    .YN (YN)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (beat),
    .sof  (i_sof & i_pixel_valid),
    .x    (px),
    .y    (py),
    .last (last)
  );

  // FSM state and all registered datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      have_q  <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
`ifdef MASK_BBOX_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      have_q  <= have_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
`ifdef MASK_BBOX_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // next state, accumulator update, publish and output handshake
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    have_d  = have_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
`ifdef MASK_BBOX_COUNT_EN
    cnt_d   = cnt_q;
`endif

    if (valid_q && i_bbox_ready) valid_d = 1'b0;

    unique case (state_q)
      WAIT_SOF: begin
        if (beat) state_d = last ? PUBLISH : ACCUM;
      end
      ACCUM: begin
        if (beat && last) state_d = PUBLISH;
      end
      PUBLISH: begin
        state_d     = WAIT_SOF;
        res_d.x_min = XW'(xmin_q);
        res_d.x_max = XW'(xmax_q);
        res_d.y_min = YW'(ymin_q);
        res_d.y_max = YW'(ymax_q);
`ifdef MASK_BBOX_COUNT_EN
        res_d.found = (cnt_q >= CN'(MIN_PIXELS));
        res_d.count = CW'(cnt_q);
        cnt_d       = '0;
`else
        res_d.found = have_q;
        res_d.count = '0;
`endif
        // overrun only when the old result is lost unaccepted
        valid_d = 1'b1;
        ovr_d   = valid_q & ~i_bbox_ready;
        have_d  = 1'b0;
        xmin_d  = '0;
        xmax_d  = '0;
        ymin_d  = '0;
        ymax_d  = '0;
      end
      default: state_d = WAIT_SOF;
    endcase

    if (beat) begin
      // sof discards any partial frame before this beat counts
      if (i_sof) begin
        have_d = 1'b0;
        xmin_d = '0;
        xmax_d = '0;
        ymin_d = '0;
        ymax_d = '0;
`ifdef MASK_BBOX_COUNT_EN
        cnt_d  = '0;
`endif
      end
      if (i_pixel) begin
        if (!have_d) begin
          xmin_d = px;
          xmax_d = px;
          ymin_d = py;
          ymax_d = py;
        end else begin
          if (px < xmin_d) xmin_d = px;
          if (px > xmax_d) xmax_d = px;
          if (py < ymin_d) ymin_d = py;
          if (py > ymax_d) ymax_d = py;
        end
        have_d = 1'b1;
`ifdef MASK_BBOX_COUNT_EN
        if (!(&cnt_d)) cnt_d = cnt_d + 1'b1;
`endif
      end
    end
  end

  assign o_bbox_valid  = valid_q;
  assign o_overrun     = ovr_q;
  assign o_found       = res_q.found;
  assign o_x_min       = res_q.x_min[XN-1:0];
  assign o_x_max       = res_q.x_max[XN-1:0];
  assign o_y_min       = res_q.y_min[YN-1:0];
  assign o_y_max       = res_q.y_max[YN-1:0];
  assign o_pixel_count = res_q.count[CN-1:0];

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Directed bench for mask_bbox_tracker on a 9x6 frame; a second
// instance with MIN_PIXELS=1 covers the single-pixel case.
module tb_mask_bbox_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_pixel = 1'b0;
  logic i_pixel_valid = 1'b0;
  logic i_sof = 1'b0;
  logic i_bbox_ready = 1'b0;

  logic       o_bbox_valid, o_found, o_overrun;
  logic [3:0] o_x_min, o_x_max;
  logic [2:0] o_y_min, o_y_max;
  logic [5:0] o_pixel_count;

  logic       v1, f1, ov1;
  logic [3:0] xn1, xx1;
  logic [2:0] yn1, yx1;
  logic [5:0] c1;

  int total = 0;
  int passed = 0;
  int ovr_cnt = 0;

  logic [8:0] rows [6];

`ifdef MASK_BBOX_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [20:0] EXP_MAIN =
    {1'b1, 4'd1, 4'd7, 3'd1, 3'd5, CNT_EN ? 6'd15 : 6'd0};
  localparam logic [20:0] EXP_ONE_MIN4 =
    {~CNT_EN, 4'd8, 4'd8, 3'd5, 3'd5, CNT_EN ? 6'd1 : 6'd0};
  localparam logic [20:0] EXP_ONE_MIN1 =
    {1'b1, 4'd8, 4'd8, 3'd5, 3'd5, CNT_EN ? 6'd1 : 6'd0};

  logic [20:0] got, got1;
  assign got  = {o_found, o_x_min, o_x_max,
                 o_y_min, o_y_max, o_pixel_count};
  assign got1 = {f1, xn1, xx1, yn1, yx1, c1};

  mask_bbox_tracker #(
    .IMG_W(9), .IMG_H(6), .MIN_PIXELS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
    .i_sof(i_sof),
    .o_bbox_valid(o_bbox_valid), .i_bbox_ready(i_bbox_ready),
    .o_found(o_found),
    .o_x_min(o_x_min), .o_x_max(o_x_max),
    .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_pixel_count(o_pixel_count), .o_overrun(o_overrun)
  );

  mask_bbox_tracker #(
    .IMG_W(9), .IMG_H(6), .MIN_PIXELS(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
    .i_sof(i_sof),
    .o_bbox_valid(v1), .i_bbox_ready(i_bbox_ready),
    .o_found(f1),
    .o_x_min(xn1), .o_x_max(xx1),
    .o_y_min(yn1), .o_y_max(yx1),
    .o_pixel_count(c1), .o_overrun(ov1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_overrun) ovr_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic pix, input logic sof);
    i_pixel_valid = 1'b1;
    i_pixel = pix;
    i_sof = sof;
    cyc();
    i_pixel_valid = 1'b0;
    i_pixel = 1'b0;
    i_sof = 1'b0;
  endtask

  task automatic send(input int first, input int lst,
                      input bit with_sof, input int gap);
    for (int k = first; k <= lst; k++) begin
      if (gap > 0) begin
        int g;
        g = $urandom_range(gap, 0);
        repeat (g) cyc();
      end
      beat(rows[k / 9][8 - (k % 9)], with_sof && (k == first));
    end
  endtask

  task automatic load_main();
    rows[0] = 9'b000000000;
    rows[1] = 9'b000011000;
    rows[2] = 9'b001100000;
    rows[3] = 9'b011110000;
    rows[4] = 9'b011110010;
    rows[5] = 9'b001100000;
  endtask

  task automatic load_fill(input logic [8:0] r);
    for (int i = 0; i < 6; i++) rows[i] = r;
  endtask

  task automatic accept();
    i_bbox_ready = 1'b1;
    cyc();
    i_bbox_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    total++;
    if ({o_bbox_valid, o_overrun, got, v1, got1} !== '0)
      $display("FAIL reset_state got %h/%h want 0",
               {o_bbox_valid, o_overrun, got}, {v1, got1});
    else passed++;
  endtask

  task automatic test_main();
    load_main();
    send(0, 53, 1'b1, 0);
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL main_publish_cycle valid=%b want 0", o_bbox_valid);
    else passed++;
    cyc();
    total++;
    if (o_bbox_valid !== 1'b1)
      $display("FAIL main_latency valid=%b want 1", o_bbox_valid);
    else passed++;
    total++;
    if (got !== EXP_MAIN)
      $display("FAIL main_result got %h want %h", got, EXP_MAIN);
    else passed++;
    repeat (3) cyc();
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_MAIN})
      $display("FAIL main_hold got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_MAIN});
    else passed++;
    accept();
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL main_accept valid=%b want 0", o_bbox_valid);
    else passed++;
    accept();
  endtask

  task automatic test_empty();
    load_fill(9'b0);
    send(0, 53, 1'b1, 0);
    cyc();
    total++;
    if ({o_bbox_valid, got} !== {1'b1, 21'd0})
      $display("FAIL empty_frame got %h want %h",
               {o_bbox_valid, got}, {1'b1, 21'd0});
    else passed++;
    accept();
  endtask

  task automatic test_single();
    load_fill(9'b0);
    rows[5] = 9'b000000001;
    send(0, 53, 1'b1, 0);
    cyc();
    total++;
    if ({v1, got1} !== {1'b1, EXP_ONE_MIN1})
      $display("FAIL single_min1 got %h want %h",
               {v1, got1}, {1'b1, EXP_ONE_MIN1});
    else passed++;
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_ONE_MIN4})
      $display("FAIL single_min4 got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_ONE_MIN4});
    else passed++;
    accept();
  endtask

  task automatic test_gaps();
    load_main();
    send(0, 53, 1'b1, 5);
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL gaps_early valid=%b want 0", o_bbox_valid);
    else passed++;
    cyc();
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_MAIN})
      $display("FAIL gaps_result got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_MAIN});
    else passed++;
    accept();
  endtask

  task automatic test_overrun();
    int base;
    load_main();
    send(0, 53, 1'b1, 0);
    cyc();
    base = ovr_cnt;
    load_fill(9'b0);
    rows[5] = 9'b000000001;
    send(0, 40, 1'b1, 0);
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_MAIN})
      $display("FAIL ovr_stable_mid got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_MAIN});
    else passed++;
    send(41, 53, 1'b0, 0);
    total++;
    if ({o_bbox_valid, o_overrun, got} !== {2'b10, EXP_MAIN})
      $display("FAIL ovr_stable_end got %h want %h",
               {o_bbox_valid, o_overrun, got}, {2'b10, EXP_MAIN});
    else passed++;
    cyc();
    total++;
    if ({o_bbox_valid, o_overrun, got} !== {2'b11, EXP_ONE_MIN4})
      $display("FAIL ovr_overwrite got %h want %h",
               {o_bbox_valid, o_overrun, got}, {2'b11, EXP_ONE_MIN4});
    else passed++;
    cyc();
    total++;
    if (o_overrun !== 1'b0)
      $display("FAIL ovr_pulse_len overrun=%b want 0", o_overrun);
    else passed++;
    total++;
    if (ovr_cnt - base !== 1)
      $display("FAIL ovr_pulse_count got %0d want 1", ovr_cnt - base);
    else passed++;
    accept();
  endtask

  task automatic test_back_to_back();
    int base;
    load_main();
    send(0, 53, 1'b1, 0);
    cyc();
    load_fill(9'b0);
    rows[5] = 9'b000000001;
    send(0, 53, 1'b1, 0);
    base = ovr_cnt;
    i_bbox_ready = 1'b1;
    cyc();
    i_bbox_ready = 1'b0;
    total++;
    if ({o_bbox_valid, o_overrun, got} !== {2'b10, EXP_ONE_MIN4})
      $display("FAIL b2b_accept_publish got %h want %h",
               {o_bbox_valid, o_overrun, got}, {2'b10, EXP_ONE_MIN4});
    else passed++;
    cyc();
    total++;
    if (ovr_cnt != base)
      $display("FAIL b2b_no_overrun got %0d want 0", ovr_cnt - base);
    else passed++;
    accept();
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL b2b_final_accept valid=%b want 0", o_bbox_valid);
    else passed++;
  endtask

  task automatic test_resync();
    load_fill(9'h1FF);
    send(0, 21, 1'b1, 0);
    load_main();
    send(0, 53, 1'b1, 0);
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL resync_no_early valid=%b want 0", o_bbox_valid);
    else passed++;
    cyc();
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_MAIN})
      $display("FAIL resync_result got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_MAIN});
    else passed++;
    accept();
    repeat (4) cyc();
    total++;
    if (o_bbox_valid !== 1'b0)
      $display("FAIL resync_single valid=%b want 0", o_bbox_valid);
    else passed++;
  endtask

  task automatic test_rst_mid();
    load_main();
    send(0, 53, 1'b1, 0);
    cyc();
    load_fill(9'h1FF);
    send(0, 29, 1'b1, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({o_bbox_valid, o_overrun, got} !== '0)
      $display("FAIL rst_mid_outputs got %h want 0",
               {o_bbox_valid, o_overrun, got});
    else passed++;
    load_main();
    send(0, 53, 1'b1, 0);
    cyc();
    total++;
    if ({o_bbox_valid, got} !== {1'b1, EXP_MAIN})
      $display("FAIL rst_mid_next got %h want %h",
               {o_bbox_valid, got}, {1'b1, EXP_MAIN});
    else passed++;
    accept();
  endtask

  initial begin
    test_reset();
    test_main();
    test_empty();
    test_single();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
